// File: rtl/mapper_pkg.sv
// Shared types and helpers for the information-mapper flow controller.
package mapper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int STALL_W = 32;
  localparam int FCNT_W  = 16;

  // Bits needed to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mapper_valid_pipe.sv
// Valid-bit shadow of the mapper pipeline; advances only when enabled.
module mapper_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_din,
  output logic o_last,
  output logic o_any,
  output logic o_any_next
);

  logic [DEPTH-1:0] r_vpipe;
  logic [DEPTH-1:0] w_next;

  generate
    if (DEPTH == 1) begin : g_d1
      assign w_next = i_en ? i_din : r_vpipe;
    end else begin : g_dn
      assign w_next = i_en ? {r_vpipe[DEPTH-2:0], i_din} : r_vpipe;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_vpipe <= '0;
    else       r_vpipe <= w_next;
  end

  assign o_last     = r_vpipe[DEPTH-1];
  assign o_any      = |r_vpipe;
  assign o_any_next = |w_next;

endmodule

// File: rtl/mapper_flow_controller.sv
// Per-frame sequencer for the information mapper: FIFO pops, clock enable, output writes.
// Optional stall/frame statistics are built when MAPPER_CTRL_STATS_EN is defined.
module mapper_flow_controller
  import mapper_pkg::*;
#(
  parameter int MAPPER_PARALLELISM = 8,
  parameter int FRAME_WORDS        = 64,
  parameter int MAPPER_LATENCY     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic frame_done,
  output logic mapper_frame_start,
  input  logic mapping_fifo_empty,
  output logic mapping_fifo_rd_req,
  input  logic data_in_fifo_empty,
  input  logic mapper_data_req,
  output logic data_in_fifo_rd_req,
  input  logic data_out_fifo_full,
  output logic data_out_fifo_wr_req,
`ifdef MAPPER_CTRL_STATS_EN
  output logic [STALL_W-1:0] stall_cycles,
  output logic [FCNT_W-1:0]  frame_count,
`endif
  output logic mapper_ce
);

  localparam int CW = cnt_width(FRAME_WORDS);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_WORDS - 1);

  generate
    if (FRAME_WORDS < 1 || MAPPER_LATENCY < 1 || MAPPER_PARALLELISM < 1) begin : g_bad_cfg
      $error("mapper_flow_controller: invalid parameter set");
    end
  endgenerate

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_word_cnt;
  logic          r_frame_done;
  logic          w_last, w_any, w_any_next;
  logic          w_out_block, w_issue, w_ce, w_start_acc;

  mapper_valid_pipe #(.DEPTH(MAPPER_LATENCY)) u_vpipe (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_ce),
    .i_din     (w_issue),
    .o_last    (w_last),
    .o_any     (w_any),
    .o_any_next(w_any_next)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_out_block = data_out_fifo_full && w_last;
    w_start_acc = start && (r_state == IDLE) && !reset;
    w_issue     = (r_state == RUN) && !mapping_fifo_empty &&
                  !(mapper_data_req && data_in_fifo_empty) && !w_out_block;
    w_ce        = 1'b0;
    case (r_state)
      IDLE:  if (w_start_acc) w_state_nxt = RUN;
      RUN: begin
        w_ce = w_issue;
        if (w_issue && r_word_cnt == LAST_CNT) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Bubbles keep flowing out; only a full FIFO facing a live word holds the pipe.
        w_ce = !w_out_block;
        if (!w_any_next) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_word_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= (r_state == DRAIN) && !w_any_next;
      if (w_start_acc)  r_word_cnt <= '0;
      else if (w_issue) r_word_cnt <= r_word_cnt + CW'(1);
    end
  end

  assign busy                 = (r_state != IDLE);
  assign frame_done           = r_frame_done;
  assign mapper_frame_start   = w_start_acc;
  assign mapper_ce            = w_ce;
  assign mapping_fifo_rd_req  = w_issue;
  assign data_in_fifo_rd_req  = w_issue && mapper_data_req;
  assign data_out_fifo_wr_req = w_ce && w_last;

`ifdef MAPPER_CTRL_STATS_EN
  logic [STALL_W-1:0] r_stall;
  logic [FCNT_W-1:0]  r_fcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
      r_fcnt  <= '0;
    end else begin
      if (r_state == RUN && !w_issue && r_stall != '1) r_stall <= r_stall + STALL_W'(1);
      if (r_frame_done) r_fcnt <= r_fcnt + FCNT_W'(1);
    end
  end

  assign stall_cycles = r_stall;
  assign frame_count  = r_fcnt;
`endif

endmodule

// File: tb/tb_mapper_flow_controller.sv
// Self-checking bench for mapper_flow_controller: directed scenarios plus a token-age reference model.
module tb_mapper_flow_controller;

  localparam int FW = 4;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done, mapper_frame_start;
  logic mapping_fifo_empty = 1'b0;
  logic mapping_fifo_rd_req;
  logic data_in_fifo_empty = 1'b0;
  logic mapper_data_req = 1'b0;
  logic data_in_fifo_rd_req;
  logic data_out_fifo_full = 1'b0;
  logic data_out_fifo_wr_req;
  logic mapper_ce;
`ifdef MAPPER_CTRL_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] frame_count;
`endif

  mapper_flow_controller #(
    .MAPPER_PARALLELISM(8), .FRAME_WORDS(FW), .MAPPER_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .mapper_frame_start(mapper_frame_start),
    .mapping_fifo_empty(mapping_fifo_empty), .mapping_fifo_rd_req(mapping_fifo_rd_req),
    .data_in_fifo_empty(data_in_fifo_empty), .mapper_data_req(mapper_data_req),
    .data_in_fifo_rd_req(data_in_fifo_rd_req),
    .data_out_fifo_full(data_out_fifo_full), .data_out_fifo_wr_req(data_out_fifo_wr_req),
`ifdef MAPPER_CTRL_STATS_EN
    .stall_cycles(stall_cycles), .frame_count(frame_count),
`endif
    .mapper_ce(mapper_ce)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase, words issued, ages of words in flight (enabled cycles since issue).
  int m_phase = 0;
  int m_cnt = 0;
  int m_age[$];
  bit m_done = 0;
  longint m_stall = 0;
  int m_fcnt = 0;
  int n_wr_f = 0, n_pop_f = 0, n_fd = 0;
  bit o_wr, o_fd, o_map, o_drd, o_ce, o_fs, o_busy;

  always @(negedge clk) begin : mon
    int old;
    bit e_last, e_blk, e_iss, e_ce, e_wr, e_fs;
    if (!reset) begin
      old    = m_phase;
      e_last = (m_age.size() > 0) && (m_age[0] == L - 1);
      e_blk  = data_out_fifo_full && e_last;
      e_iss  = (old == 1) && !mapping_fifo_empty && !(mapper_data_req && data_in_fifo_empty) && !e_blk;
      e_ce   = (old == 1) ? e_iss : (old == 2) ? !e_blk : 1'b0;
      e_wr   = e_ce && e_last;
      e_fs   = start && (old == 0);
      o_wr = data_out_fifo_wr_req; o_fd = frame_done; o_map = mapping_fifo_rd_req;
      o_drd = data_in_fifo_rd_req; o_ce = mapper_ce; o_fs = mapper_frame_start; o_busy = busy;
      n_chk += 7;
      if (busy !== (old != 0)) begin n_fail++; $display("FAIL model_busy t=%0t got %b want %b", $time, busy, old != 0); end
      if (mapper_ce !== e_ce) begin n_fail++; $display("FAIL model_ce t=%0t got %b want %b", $time, mapper_ce, e_ce); end
      if (mapping_fifo_rd_req !== e_iss) begin n_fail++; $display("FAIL model_map_rd t=%0t got %b want %b", $time, mapping_fifo_rd_req, e_iss); end
      if (data_in_fifo_rd_req !== (e_iss && mapper_data_req)) begin n_fail++; $display("FAIL model_data_rd t=%0t got %b want %b", $time, data_in_fifo_rd_req, e_iss && mapper_data_req); end
      if (data_out_fifo_wr_req !== e_wr) begin n_fail++; $display("FAIL model_wr t=%0t got %b want %b", $time, data_out_fifo_wr_req, e_wr); end
      if (mapper_frame_start !== e_fs) begin n_fail++; $display("FAIL model_fstart t=%0t got %b want %b", $time, mapper_frame_start, e_fs); end
      if (frame_done !== m_done) begin n_fail++; $display("FAIL model_done t=%0t got %b want %b", $time, frame_done, m_done); end
`ifdef MAPPER_CTRL_STATS_EN
      n_chk += 2;
      if (stall_cycles !== 32'(m_stall)) begin n_fail++; $display("FAIL model_stall t=%0t got %0d want %0d", $time, stall_cycles, m_stall); end
      if (frame_count !== 16'(m_fcnt)) begin n_fail++; $display("FAIL model_fcount t=%0t got %0d want %0d", $time, frame_count, m_fcnt); end
`endif
      // Per-frame totals from the DUT's own strobes.
      if (data_out_fifo_wr_req) n_wr_f++;
      if (mapping_fifo_rd_req) n_pop_f++;
      if (frame_done) begin
        n_fd++;
        n_chk += 2;
        if (n_wr_f !== FW) begin n_fail++; $display("FAIL frame_writes got %0d want %0d", n_wr_f, FW); end
        if (n_pop_f !== FW) begin n_fail++; $display("FAIL frame_pops got %0d want %0d", n_pop_f, FW); end
        n_wr_f = 0; n_pop_f = 0;
      end
      if (e_ce) begin
        if (e_last) void'(m_age.pop_front());
        foreach (m_age[i]) m_age[i]++;
        if (e_iss) m_age.push_back(0);
      end
      if (old == 1 && !e_iss && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_done) m_fcnt = (m_fcnt + 1) % 65536;
      if (e_iss) begin m_cnt++; if (m_cnt == FW) m_phase = 2; end
      m_done = 0;
      if (old == 2 && m_age.size() == 0) begin m_done = 1; m_phase = 0; end
      if (e_fs) begin m_phase = 1; m_cnt = 0; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_age.delete(); m_done = 0; m_stall = 0; m_fcnt = 0;
    n_wr_f = 0; n_pop_f = 0;
  endtask

  task automatic ready_all();
    start = 0; mapping_fifo_empty = 0; data_in_fifo_empty = 0; data_out_fifo_full = 0; mapper_data_req = 0;
  endtask

  task automatic run_to_done(input string name);
    int k;
    for (k = 0; k < 200 && !o_fd; k++) begin
      mapper_data_req = 1'($urandom);
      tick();
    end
    n_chk++;
    if (!o_fd) begin n_fail++; $display("FAIL %s_timeout got no frame_done want frame_done", name); end
    start = 0;
  endtask

  task automatic test_reset();
    #1;
    n_chk += 6;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (mapper_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %b want 0", mapper_ce); end
    if (mapping_fifo_rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_map_rd got %b want 0", mapping_fifo_rd_req); end
    if (data_in_fifo_rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_data_rd got %b want 0", data_in_fifo_rd_req); end
    if (data_out_fifo_wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", data_out_fifo_wr_req); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", frame_done); end
    #6 reset = 0;
    tick();
  endtask

  task automatic test_basic();
    bit req;
    ready_all();
    for (int k = 0; k < 10; k++) begin
      start = (k == 0);
      req = 1'($urandom);
      mapper_data_req = req;
      tick();
      n_chk += 4;
      if (o_map !== (k >= 1 && k <= 4)) begin n_fail++; $display("FAIL basic_map_pop c%0d got %b want %b", k, o_map, k >= 1 && k <= 4); end
      if (o_drd !== (k >= 1 && k <= 4 && req)) begin n_fail++; $display("FAIL basic_data_pop c%0d got %b want %b", k, o_drd, k >= 1 && k <= 4 && req); end
      if (o_wr !== (k >= 3 && k <= 6)) begin n_fail++; $display("FAIL basic_wr c%0d got %b want %b", k, o_wr, k >= 3 && k <= 6); end
      if (o_fd !== (k == 7)) begin n_fail++; $display("FAIL basic_done c%0d got %b want %b", k, o_fd, k == 7); end
      if (k >= 8) begin
        n_chk++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle c%0d got %b want 0", k, o_busy); end
      end
    end
  endtask

  task automatic test_map_stall();
`ifdef MAPPER_CTRL_STATS_EN
    logic [31:0] s0;
    s0 = stall_cycles;
`endif
    ready_all();
    start = 1; tick(); start = 0;
    tick(); tick();
    mapping_fifo_empty = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk += 2;
      if (o_map !== 1'b0) begin n_fail++; $display("FAIL mapstall_pop c%0d got %b want 0", k, o_map); end
      if (o_ce !== 1'b0) begin n_fail++; $display("FAIL mapstall_ce c%0d got %b want 0", k, o_ce); end
    end
    mapping_fifo_empty = 0;
    run_to_done("mapstall");
`ifdef MAPPER_CTRL_STATS_EN
    n_chk++;
    if (stall_cycles - s0 !== 32'd3) begin n_fail++; $display("FAIL mapstall_stats got %0d want 3", stall_cycles - s0); end
`endif
    tick();
  endtask

  task automatic test_data_stall();
    ready_all();
    start = 1; tick(); start = 0;
    tick();
    data_in_fifo_empty = 1; mapper_data_req = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk += 3;
      if (o_map !== 1'b0) begin n_fail++; $display("FAIL datastall_pop c%0d got %b want 0", k, o_map); end
      if (o_drd !== 1'b0) begin n_fail++; $display("FAIL datastall_drd c%0d got %b want 0", k, o_drd); end
      if (o_ce !== 1'b0) begin n_fail++; $display("FAIL datastall_ce c%0d got %b want 0", k, o_ce); end
    end
    mapper_data_req = 0;
    tick();
    n_chk += 2;
    if (o_map !== 1'b1) begin n_fail++; $display("FAIL datanoreq_pop got %b want 1", o_map); end
    if (o_drd !== 1'b0) begin n_fail++; $display("FAIL datanoreq_drd got %b want 0", o_drd); end
    data_in_fifo_empty = 0;
    run_to_done("datastall");
    tick();
  endtask

  task automatic test_backpressure();
    int k;
    ready_all();
    start = 1; tick(); start = 0;
    for (k = 0; k < 20 && !o_wr; k++) tick();
    data_out_fifo_full = 1;
    for (k = 0; k < 5; k++) begin
      tick();
      n_chk += 3;
      if (o_map !== 1'b0) begin n_fail++; $display("FAIL bp_pop c%0d got %b want 0", k, o_map); end
      if (o_wr !== 1'b0) begin n_fail++; $display("FAIL bp_wr c%0d got %b want 0", k, o_wr); end
      if (o_ce !== 1'b0) begin n_fail++; $display("FAIL bp_ce c%0d got %b want 0", k, o_ce); end
    end
    data_out_fifo_full = 0;
    run_to_done("bp");
    tick();
  endtask

  task automatic test_start_ignored();
    int fd0;
    ready_all();
    fd0 = n_fd;
    start = 1; tick();
    for (int k = 0; k < 12; k++) begin
      start = (k % 2 == 0);
      mapper_data_req = 1'($urandom);
      tick();
      n_chk++;
      if (o_fs !== 1'b0 && o_busy) begin n_fail++; $display("FAIL startign_fs c%0d got %b want 0", k, o_fs); end
      if (o_fd) start = 0;
      if (o_fd) break;
    end
    start = 0;
    tick(); tick();
    n_chk++;
    if (n_fd - fd0 !== 1) begin n_fail++; $display("FAIL startign_done_count got %0d want 1", n_fd - fd0); end
  endtask

  task automatic test_reset_in_drain();
    int k, fd0;
    ready_all();
    start = 1; tick(); start = 0;
    for (k = 0; k < 20 && m_phase != 2; k++) tick();
    #2 reset = 1;
    #1;
    model_reset();
    n_chk += 5;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstdrain_busy got %b want 0", busy); end
    if (mapper_ce !== 1'b0) begin n_fail++; $display("FAIL rstdrain_ce got %b want 0", mapper_ce); end
    if (data_out_fifo_wr_req !== 1'b0) begin n_fail++; $display("FAIL rstdrain_wr got %b want 0", data_out_fifo_wr_req); end
    if (mapping_fifo_rd_req !== 1'b0) begin n_fail++; $display("FAIL rstdrain_pop got %b want 0", mapping_fifo_rd_req); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rstdrain_done got %b want 0", frame_done); end
    @(posedge clk); #2 reset = 0;
    fd0 = n_fd;
    tick(); tick(); tick();
    n_chk++;
    if (n_fd !== fd0) begin n_fail++; $display("FAIL rstdrain_no_done got %0d want %0d", n_fd, fd0); end
    start = 1; tick(); start = 0;
    run_to_done("rstdrain_restart");
    tick();
  endtask

  task automatic test_random();
    int fd0, k;
    fd0 = n_fd;
    for (k = 0; k < 3000 && n_fd - fd0 < 8; k++) begin
      start              = ($urandom_range(0, 3) == 0);
      mapping_fifo_empty = ($urandom_range(0, 3) == 0);
      data_in_fifo_empty = ($urandom_range(0, 3) == 0);
      mapper_data_req    = 1'($urandom);
      data_out_fifo_full = ($urandom_range(0, 2) == 0);
      tick();
    end
    ready_all();
    n_chk++;
    if (n_fd - fd0 < 8) begin n_fail++; $display("FAIL random_frames got %0d want 8", n_fd - fd0); end
    for (k = 0; k < 100 && o_busy; k++) tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_map_stall();
    test_data_stall();
    test_backpressure();
    test_start_ignored();
    test_reset_in_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
